// File: rtl/cv32e40x_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40x_pkg
// Purpose : Shared types and constants for the XIF AES coprocessor path.
//           Holds the mask-generator state encoding, the PRNG feedback
//           polynomial and the operand widths shared with cv32e40x_xif_aes.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cv32e40x_pkg;

    // Widths shared between the mask generator and the protected AES unit
    localparam int AES_RAND_WIDTH  = 36;
    localparam int AES_SHARE_WIDTH = 8;

    // Tap mask for x^64 + x^63 + x^61 + x^60 + 1 (bits 63, 62, 60, 59)
    localparam logic [63:0] AES_RNG_POLY = 64'hD800_0000_0000_0000;

    typedef enum logic [1:0] {
        RNG_FILL = 2'd0,
        RNG_RUN  = 2'd1,
        RNG_ERR  = 2'd2
    } aes_rng_state_e;

    // One single-bit Fibonacci step: shift left, feedback into bit 0
    function automatic logic [63:0] aes_rng_step(input logic [63:0] s);
        return {s[62:0], ^(s & AES_RNG_POLY)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40x_aes_rng_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40x_aes_rng_lfsr
// Purpose : Purely combinational 64-step unroll of the mask-generator LFSR.
//           One evaluation produces the state 64 single-bit steps ahead and
//           the low WORD_WIDTH bits of that state as the mask word.
// Ports   : state_i      - current 64-bit LFSR state
//           next_state_o - state after 64 steps
//           word_o       - next_state_o[WORD_WIDTH-1:0]
// Revision: 1.0 - initial release
// ============================================================================
module cv32e40x_aes_rng_lfsr
    import cv32e40x_pkg::*;
#(
    parameter int WORD_WIDTH = AES_RAND_WIDTH + AES_SHARE_WIDTH
) (
    input  logic [63:0]           state_i,
    output logic [63:0]           next_state_o,
    output logic [WORD_WIDTH-1:0] word_o
);

    logic [63:0] unroll;

    always_comb begin
        unroll = state_i;
        for (int i = 0; i < 64; i++) begin
            unroll = aes_rng_step(unroll);
        end
    end

    assign next_state_o = unroll;
    assign word_o       = unroll[WORD_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/cv32e40x_xif_aes_rng.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40x_xif_aes_rng
// Purpose : Mask-word source for the protected AES unit. A small prefetch
//           FIFO is kept topped up from a 64-bit LFSR so that every accepted
//           AES32 instruction can take a fresh {shareB, randombits} word with
//           no added latency. Includes reseeding and a sticky repetition
//           health check.
// Ports   : clk_i, rst_n (async, active-low)
//           seed_valid_i / seed_i / seed_ready_o - reseed handshake
//           req_i        - consumer takes the head word this cycle
//           rand_valid_o - head word available
//           randombits_o - head random bits (0 when not valid)
//           shareB_o     - head multiplicative share, nonzero when valid
//           level_o      - FIFO occupancy
//           health_err_o - sticky repetition failure
// Revision: 1.0 - initial release
// ============================================================================
module cv32e40x_xif_aes_rng
    import cv32e40x_pkg::*;
#(
    parameter int              RAND_WIDTH   = AES_RAND_WIDTH,
    parameter int              SHARE_WIDTH  = AES_SHARE_WIDTH,
    parameter int              FIFO_DEPTH   = 4,
    parameter int              LFSR_WIDTH   = 64,
    parameter logic [63:0]     SEED_DEFAULT = 64'h9E37_79B9_7F4A_7C15
) (
    input  logic                             clk_i,
    input  logic                             rst_n,
    input  logic                             seed_valid_i,
    input  logic [63:0]                      seed_i,
    output logic                             seed_ready_o,
    input  logic                             req_i,
    output logic                             rand_valid_o,
    output logic [RAND_WIDTH-1:0]            randombits_o,
    output logic [SHARE_WIDTH-1:0]           shareB_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level_o,
    output logic                             health_err_o
);

    localparam int WORD_WIDTH = RAND_WIDTH + SHARE_WIDTH;
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(FIFO_DEPTH);

    aes_rng_state_e          state;
    logic [LFSR_WIDTH-1:0]   lfsr;
    logic [LFSR_WIDTH-1:0]   lfsr_next;
    logic [LFSR_WIDTH-1:0]   seed_mix;
    logic [WORD_WIDTH-1:0]   lfsr_word;
    logic [WORD_WIDTH-1:0]   prev_word;
    logic [PTR_WIDTH-1:0]    rd_ptr;
    logic [PTR_WIDTH-1:0]    wr_ptr;
    logic [CNT_WIDTH-1:0]    count;
    logic [CNT_WIDTH-1:0]    count_next;
    logic [RAND_WIDTH-1:0]   rand_mem  [FIFO_DEPTH];
    logic [SHARE_WIDTH-1:0]  share_mem [FIFO_DEPTH];
    logic [SHARE_WIDTH-1:0]  gen_share;
    logic                    pop;
    logic                    reseed;
    logic                    gen;
    logic                    repeat_hit;
    logic                    push;

    cv32e40x_aes_rng_lfsr #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_lfsr (
        .state_i      (lfsr),
        .next_state_o (lfsr_next),
        .word_o       (lfsr_word)
    );

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign rand_valid_o = (count != '0) && !health_err_o;
    assign pop          = req_i && rand_valid_o;
    assign reseed       = seed_valid_i && seed_ready_o;

    // A pop frees the slot the same cycle, so a full FIFO still refills.
    // The LFSR only advances when a word is actually generated.
    assign gen        = !reseed && (state != RNG_ERR) && ((count != FULL_COUNT) || pop);
    assign repeat_hit = gen && (lfsr_word == prev_word);
    assign push       = gen && !repeat_hit;

    assign count_next = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

    // A zero share would collapse the multiplicative masking, so it is
    // replaced by 1 rather than regenerated (keeps refill at one cycle).
    assign gen_share = (lfsr_word[WORD_WIDTH-1:RAND_WIDTH] == '0)
                     ? SHARE_WIDTH'(1)
                     : lfsr_word[WORD_WIDTH-1:RAND_WIDTH];

    assign seed_mix = lfsr ^ seed_i;

    // ------------------------------------------------------------------
    // State, pointers, LFSR and health tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RNG_FILL;
            lfsr         <= SEED_DEFAULT;
            prev_word    <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            health_err_o <= 1'b0;
            seed_ready_o <= 1'b0;
        end else begin
            seed_ready_o <= 1'b1;
            if (reseed) begin
                // Any same-cycle pop has already been served from the old
                // head; the flush simply discards the rest.
                lfsr         <= (seed_mix == '0) ? SEED_DEFAULT : seed_mix;
                prev_word    <= '0;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count        <= '0;
                health_err_o <= 1'b0;
                state        <= RNG_FILL;
            end else begin
                if (gen) begin
                    lfsr <= lfsr_next;
                end
                if (push) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    prev_word <= lfsr_word;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count_next;

                case (state)
                    RNG_FILL: begin
                        if (repeat_hit) begin
                            health_err_o <= 1'b1;
                            state        <= RNG_ERR;
                        end else if (count_next == FULL_COUNT) begin
                            state <= RNG_RUN;
                        end
                    end
                    RNG_RUN: begin
                        if (repeat_hit) begin
                            health_err_o <= 1'b1;
                            state        <= RNG_ERR;
                        end
                    end
                    default: begin
                        state <= RNG_ERR;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents are qualified by count, so no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            rand_mem[wr_ptr]  <= lfsr_word[RAND_WIDTH-1:0];
            share_mem[wr_ptr] <= gen_share;
        end
    end

    assign randombits_o = rand_valid_o ? rand_mem[rd_ptr]  : '0;
    assign shareB_o     = rand_valid_o ? share_mem[rd_ptr] : '0;
    assign level_o      = count;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_xif_aes_rng.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_cv32e40x_xif_aes_rng
// Purpose : Directed self-checking bench for cv32e40x_xif_aes_rng with a
//           cycle-level reference model and an expected-word queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cv32e40x_xif_aes_rng;

    localparam logic [63:0] DEF_SEED = 64'h9E37_79B9_7F4A_7C15;
    localparam logic [43:0] FORCED   = 44'h5A5_C3C3_1234;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_valid_i = 1'b0;
    logic [63:0] seed_i = 64'h0;
    logic        req_i = 1'b0;
    logic        seed_ready_o;
    logic        rand_valid_o;
    logic [35:0] randombits_o;
    logic [7:0]  shareB_o;
    logic [2:0]  level_o;
    logic        health_err_o;

    logic [63:0] chk_state;
    logic [63:0] chk_next;
    logic [43:0] chk_word;

    always #5 clk_i = ~clk_i;

    cv32e40x_xif_aes_rng dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .seed_valid_i (seed_valid_i),
        .seed_i       (seed_i),
        .seed_ready_o (seed_ready_o),
        .req_i        (req_i),
        .rand_valid_o (rand_valid_o),
        .randombits_o (randombits_o),
        .shareB_o     (shareB_o),
        .level_o      (level_o),
        .health_err_o (health_err_o)
    );

    cv32e40x_aes_rng_lfsr u_chk (
        .state_i      (chk_state),
        .next_state_o (chk_next),
        .word_o       (chk_word)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] m_lfsr;
    logic [43:0] m_prev;
    logic        m_err;
    logic        m_ready;
    logic        force_on;
    logic [43:0] exp_q[$];
    logic [43:0] reset_words[4];
    int          lvl_tab[6] = '{1, 2, 3, 4, 4, 4};

    function automatic logic [63:0] model_step64(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < 64; i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    function automatic logic [43:0] fix_share(input logic [43:0] w);
        return (w[43:36] == 8'h00) ? {8'h01, w[35:0]} : w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        v;
        logic [43:0] head;
        v    = (exp_q.size() != 0) && !m_err;
        head = v ? exp_q[0] : 44'h0;
        chk("rand_valid", 64'(rand_valid_o), 64'(v));
        chk("level",      64'(level_o),      64'(exp_q.size()));
        chk("health_err", 64'(health_err_o), 64'(m_err));
        chk("randombits", 64'(randombits_o), 64'(head[35:0]));
        chk("shareB",     64'(shareB_o),     64'(head[43:36]));
        chk("seed_ready", 64'(seed_ready_o), 64'(m_ready));
    endtask

    // Advance the model by one clock using the currently driven inputs,
    // then clock the DUT and compare.
    task automatic cycle();
        logic        pop;
        logic        room;
        logic [63:0] x;
        logic [43:0] w;
        logic [43:0] dropped;
        pop = req_i && (exp_q.size() != 0) && !m_err;
        if (seed_valid_i && m_ready) begin
            exp_q.delete();
            x      = m_lfsr ^ seed_i;
            m_lfsr = (x == 64'h0) ? DEF_SEED : x;
            m_prev = 44'h0;
            m_err  = 1'b0;
        end else if (!m_err) begin
            room = (exp_q.size() < 4) || pop;
            if (pop) dropped = exp_q.pop_front();
            if (room) begin
                m_lfsr = model_step64(m_lfsr);
                w = force_on ? FORCED : m_lfsr[43:0];
                if (w == m_prev) begin
                    m_err = 1'b1;
                end else begin
                    exp_q.push_back(fix_share(w));
                    m_prev = w;
                end
            end
        end
        @(posedge clk_i);
        #1;
        m_ready = 1'b1;
        check_outputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] s;
        logic [63:0] zs;
        logic [43:0] first_w;
        logic [63:0] tmp;
        bit          found;

        m_lfsr   = DEF_SEED;
        m_prev   = 44'h0;
        m_err    = 1'b0;
        m_ready  = 1'b0;
        force_on = 1'b0;
        chk_state = 64'h1;

        // Combinational unroll in isolation
        for (int i = 0; i < 3; i++) begin
            chk_state = (i == 0) ? DEF_SEED : {$urandom, $urandom} | 64'h1;
            #1;
            tmp = model_step64(chk_state);
            chk("lfsr_next", chk_next, tmp);
            chk("lfsr_word", 64'(chk_word), 64'(tmp[43:0]));
        end

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Fill from reset, no requests
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("fill_level", 64'(level_o), 64'(lvl_tab[i]));
        end
        for (int i = 0; i < 4; i++) reset_words[i] = exp_q[i];

        // Streaming: one pop per cycle on a full FIFO
        req_i = 1'b1;
        repeat (10) begin
            cycle();
            chk("stream_level", 64'(level_o), 64'd4);
        end
        req_i = 1'b0;

        // Reseed with a same-cycle pop
        req_i        = 1'b1;
        seed_valid_i = 1'b1;
        seed_i       = 64'h0123_4567_89AB_CDEF;
        tmp          = model_step64(m_lfsr ^ seed_i);
        first_w      = fix_share(tmp[43:0]);
        cycle();
        req_i        = 1'b0;
        seed_valid_i = 1'b0;
        chk("reseed_flush_level", 64'(level_o), 64'd0);
        cycle();
        chk("post_reseed_valid", 64'(rand_valid_o), 64'd1);
        chk("post_reseed_word", 64'({shareB_o, randombits_o}), 64'(first_w));
        repeat (4) cycle();

        // Seed equal to the current state restarts the reset sequence
        seed_valid_i = 1'b1;
        seed_i       = m_lfsr;
        cycle();
        seed_valid_i = 1'b0;
        repeat (4) cycle();
        req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("restart_word", 64'({shareB_o, randombits_o}), 64'(reset_words[i]));
            cycle();
        end
        req_i = 1'b0;

        // Zero share byte gets replaced by 1
        found = 1'b0;
        zs    = 64'h0;
        for (int i = 0; i < 20000 && !found; i++) begin
            s   = {$urandom, $urandom};
            tmp = model_step64(s);
            if (s != 64'h0 && tmp[43:36] == 8'h00 && tmp[35:0] != 36'h0) begin
                found = 1'b1;
                zs    = s;
            end
        end
        chk("zero_share_search", 64'(found), 64'd1);
        tmp          = model_step64(zs);
        seed_valid_i = 1'b1;
        seed_i       = m_lfsr ^ zs;
        cycle();
        seed_valid_i = 1'b0;
        cycle();
        chk("zero_share_fixed", 64'(shareB_o), 64'h01);
        chk("zero_share_bits", 64'(randombits_o), 64'(tmp[35:0]));

        // Repetition health failure
        seed_valid_i = 1'b1;
        seed_i       = 64'hFEED_FACE_CAFE_BEEF;
        cycle();
        seed_valid_i = 1'b0;
        force dut.lfsr_word = FORCED;
        force_on = 1'b1;
        cycle();
        chk("forced_first_push", 64'(level_o), 64'd1);
        cycle();
        chk("health_set", 64'(health_err_o), 64'd1);
        chk("health_valid_low", 64'(rand_valid_o), 64'd0);
        req_i = 1'b1;
        repeat (2) cycle();
        chk("health_req_ignored", 64'(level_o), 64'd1);
        req_i = 1'b0;
        release dut.lfsr_word;
        force_on = 1'b0;
        seed_valid_i = 1'b1;
        seed_i       = 64'h1357_9BDF_2468_ACE0;
        cycle();
        seed_valid_i = 1'b0;
        chk("health_cleared", 64'(health_err_o), 64'd0);
        repeat (2) cycle();
        chk("refill_after_clear", 64'(level_o), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cv32e40x_xif_aes_rng.md
Name: cv32e40x_xif_aes_rng

Overview:
Randomness source for the masked (PROTECTED) AES coprocessor path. It keeps a small prefetch FIFO of fresh mask words. Each word is a randombits vector plus a nonzero shareB byte, so every accepted AES32 instruction gets unique randomness with zero added latency. It sits directly upstream of the protected AES functional unit. The consumer pops one word per accepted instruction.

Parameters:
RAND_WIDTH, 36, width of randombits_o per AES operation.
SHARE_WIDTH, 8, width of shareB_o.
FIFO_DEPTH, 4, prefetch entries; power of two, 2 to 16.
LFSR_WIDTH, 64, PRNG state width; fixed at 64, which must be at least RAND_WIDTH+SHARE_WIDTH.
SEED_DEFAULT, 64'h9E37_79B9_7F4A_7C15, reset LFSR state; must be nonzero.

Ports:
clk_i  in  1  clock
rst_n  in  1  reset
seed_valid_i  in  1  reseed request
seed_i  in  64  external entropy word
seed_ready_o  out  1  reseed accepted when high together with seed_valid_i
req_i  in  1  consumer takes head word this cycle
rand_valid_o  out  1  head word available
randombits_o  out  RAND_WIDTH  head word random bits
shareB_o  out  SHARE_WIDTH  head word multiplicative share, never zero when valid
level_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
health_err_o  out  1  sticky repetition failure

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk_i.
- Reset values:
  - lfsr = SEED_DEFAULT, count = 0, prev_word = 0, state = FILL.
  - Outputs: rand_valid_o = 0, randombits_o = 0, shareB_o = 0, level_o = 0, health_err_o = 0, seed_ready_o = 0.
- PRNG:
  - Fibonacci LFSR with polynomial x^64+x^63+x^61+x^60+1.
  - One generate cycle advances the LFSR 64 single-bit steps, fully unrolled in combinational logic.
  - The generated word is the new state [43:0].
  - randombits = word[35:0]; share = word[43:36]. If share == 0, 8'h01 is stored instead.
- FSM:
  - FILL: seed_ready_o = 1. Push one generated word per cycle. Go to RUN on the cycle count reaches FIFO_DEPTH.
  - RUN: seed_ready_o = 1. Push when !full or when a pop occurs the same cycle; a simultaneous pop and push when full leaves count unchanged.
  - ERR: entered when health_err_o sets. No pushes. seed_ready_o = 1.
- Pop and head outputs:
  - pop = req_i && rand_valid_o.
  - req_i while empty or in ERR: no effect, no error.
  - rand_valid_o = (count != 0) && !health_err_o.
  - randombits_o and shareB_o show the head entry when rand_valid_o is high, else 0.
- Latency:
  - The first word is pushed on the first clk_i edge after rst_n deasserts, so rand_valid_o is high in cycle 1.
  - The FIFO is full after FIFO_DEPTH cycles.
  - Pop-to-refill: one cycle.
- Reseed (seed_valid_i && seed_ready_o):
  - lfsr <= lfsr XOR seed_i. If the result is zero, lfsr <= SEED_DEFAULT.
  - FIFO is flushed (count = 0), health_err_o is cleared, prev_word = 0, state = FILL.
  - A pop in the same cycle completes on the old head before the flush takes effect.
  - No push occurs in the reseed cycle.
- Health check:
  - Every generated word is compared with prev_word. If equal, health_err_o sets (sticky) and the FSM goes to ERR.
  - The matching word is not pushed.
  - Only reseed or reset clears health_err_o.
- FIFO: circular buffer; read and write pointers wrap modulo FIFO_DEPTH; count is held separately.

Decomposition:
- Shared package cv32e40x_pkg gets:
  - typedef aes_rng_state_e {RNG_FILL, RNG_RUN, RNG_ERR}
  - constant AES_RNG_POLY = 64'hD800_0000_0000_0000
  - constants AES_RAND_WIDTH = 36 and AES_SHARE_WIDTH = 8, shared with cv32e40x_xif_aes.
- One sub-module: cv32e40x_aes_rng_lfsr. It takes state_i and returns next_state_o and word_o, and is purely combinational (64-step unroll). This keeps the FIFO and FSM logic separate and lets the bench check it in isolation.

Test Plan:
- Reset release, req_i = 0 for 6 cycles -> rand_valid_o high from cycle 1; level_o = 1, 2, 3, 4, 4, 4; words match the golden LFSR model seeded with SEED_DEFAULT.
- Full FIFO, req_i held high for 10 cycles -> one pop per cycle; level_o stays 4; 10 distinct words in model order.
- Drain faster than refill is impossible at one pop per cycle. Instead, reseed with a pop in the same cycle -> the old head is consumed, then level_o = 0; rand_valid_o = 1 one cycle later with the model word from lfsr XOR seed.
- seed_i = current lfsr value (XOR result zero) -> lfsr = SEED_DEFAULT; the output sequence restarts identically to the post-reset sequence.
- Force a word with bits [43:36] = 0 (seed chosen via the model) -> shareB_o = 8'h01 and randombits_o unchanged.
- Force the LFSR to repeat a word (bench forces the sub-module output) -> health_err_o = 1, rand_valid_o = 0, req_i ignored; a subsequent reseed clears it and filling resumes.
